// File: rtl/stream_demux1_2_if.sv
// Stream demux bus: one valid/ready input stream, two routed output channels,
// and per-channel completed-packet counters.
interface stream_demux1_2_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 4
);
  logic [WIDTH-1:0]     in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic                 sel;

  logic [WIDTH-1:0]     out_a;
  logic                 out_a_valid;
  logic                 out_a_last;
  logic                 out_a_ready;

  logic [WIDTH-1:0]     out_b;
  logic                 out_b_valid;
  logic                 out_b_last;
  logic                 out_b_ready;

  logic [CNT_WIDTH-1:0] count_a;
  logic [CNT_WIDTH-1:0] count_b;

  // Demux side
  modport slave (
    input  in_data, in_valid, in_last, sel, out_a_ready, out_b_ready,
    output in_ready,
    output out_a, out_a_valid, out_a_last,
    output out_b, out_b_valid, out_b_last,
    output count_a, count_b
  );

  // Environment side: upstream producer plus both consumers
  modport master (
    output in_data, in_valid, in_last, sel, out_a_ready, out_b_ready,
    input  in_ready,
    input  out_a, out_a_valid, out_a_last,
    input  out_b, out_b_valid, out_b_last,
    input  count_a, count_b
  );
endinterface

// File: rtl/stream_demux1_2.sv
// Registered 1:2 packet demultiplexer. SEL picks the channel on a packet's
// first beat; the route is locked until the last beat. Each output channel
// has a one-entry holding register that drains independently.
module stream_demux1_2 #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  stream_demux1_2_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTE_A = 2'd1,
    ROUTE_B = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_data_q, a_data_d;
  logic                 a_valid_q, a_valid_d;
  logic                 a_last_q, a_last_d;
  logic [WIDTH-1:0]     b_data_q, b_data_d;
  logic                 b_valid_q, b_valid_d;
  logic                 b_last_q, b_last_d;
  logic [CNT_WIDTH-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_WIDTH-1:0] cnt_b_q, cnt_b_d;

  logic tgt_b_c;
  logic in_ready_c;
  logic accept_c;

  // Target selection and input readiness; only the target channel gates ready
  always_comb begin
    tgt_b_c    = (state_q == ROUTE_B) || ((state_q == IDLE) && bus.sel);
    in_ready_c = 1'b0;
    if (!rst) begin
      if (tgt_b_c) in_ready_c = !b_valid_q || bus.out_b_ready;
      else         in_ready_c = !a_valid_q || bus.out_a_ready;
    end
    accept_c = bus.in_valid && in_ready_c;
  end

  // Next state, output holding registers and counters
  always_comb begin
    state_d   = state_q;
    a_data_d  = a_data_q;
    a_valid_d = a_valid_q;
    a_last_d  = a_last_q;
    b_data_d  = b_data_q;
    b_valid_d = b_valid_q;
    b_last_d  = b_last_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;

    // Drain first; a load on the same edge overrides it below
    if (a_valid_q && bus.out_a_ready) a_valid_d = 1'b0;
    if (b_valid_q && bus.out_b_ready) b_valid_d = 1'b0;

    if (accept_c) begin
      if (tgt_b_c) begin
        b_data_d  = bus.in_data;
        b_last_d  = bus.in_last;
        b_valid_d = 1'b1;
        if (bus.in_last) cnt_b_d = cnt_b_q + CNT_WIDTH'(1);
      end else begin
        a_data_d  = bus.in_data;
        a_last_d  = bus.in_last;
        a_valid_d = 1'b1;
        if (bus.in_last) cnt_a_d = cnt_a_q + CNT_WIDTH'(1);
      end

      if (bus.in_last) state_d = IDLE;
      else             state_d = tgt_b_c ? ROUTE_B : ROUTE_A;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_data_q  <= '0;
      a_valid_q <= 1'b0;
      a_last_q  <= 1'b0;
      b_data_q  <= '0;
      b_valid_q <= 1'b0;
      b_last_q  <= 1'b0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      a_data_q  <= a_data_d;
      a_valid_q <= a_valid_d;
      a_last_q  <= a_last_d;
      b_data_q  <= b_data_d;
      b_valid_q <= b_valid_d;
      b_last_q  <= b_last_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_a       = a_data_q;
  assign bus.out_a_valid = a_valid_q;
  assign bus.out_a_last  = a_last_q;
  assign bus.out_b       = b_data_q;
  assign bus.out_b_valid = b_valid_q;
  assign bus.out_b_last  = b_last_q;
  assign bus.count_a     = cnt_a_q;
  assign bus.count_b     = cnt_b_q;

endmodule

// File: tb/tb_stream_demux1_2.sv
// Bench for stream_demux1_2: directed vector table, hand-written reset and
// counter-wrap sequences, then randomized traffic against a queue-based model.
module tb_stream_demux1_2;

  logic clk;
  logic rst;

  stream_demux1_2_if #(.WIDTH(8), .CNT_WIDTH(4)) bus ();

  stream_demux1_2 #(.WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       v, l, s, ra, rb;
    logic       rdy;
    logic       av;
    logic [7:0] ad;
    logic       al;
    logic       bv;
    logic [7:0] bd;
    logic       bl;
    logic [3:0] ca, cb;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: each output slot is a queue of at most one {last,data}
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  int lock;
  int mcnt_a, mcnt_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic l,
                       input logic s, input logic ra, input logic rb);
    bus.in_data     = d;
    bus.in_valid    = v;
    bus.in_last     = l;
    bus.sel         = s;
    bus.out_a_ready = ra;
    bus.out_b_ready = rb;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({nm, "_outs"}, {bus.out_a, bus.out_a_valid, bus.out_a_last,
                        bus.out_b, bus.out_b_valid, bus.out_b_last,
                        bus.count_a, bus.count_b}, 32'd0);
  endtask

  // Assert reset between edges, check outputs clear immediately, release later
  task automatic async_reset(input string nm);
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1 chk_all_zero(nm);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    //               d     v l s ra rb rdy av ad    al bv bd    bl ca    cb
    vecs.push_back('{8'h5A,1,1,0,1,1, 1, 1,8'h5A,1, 0,8'h00,0, 4'd1,4'd0});
    vecs.push_back('{8'h01,1,0,1,1,1, 1, 0,8'h5A,1, 1,8'h01,0, 4'd1,4'd0});
    vecs.push_back('{8'h02,1,0,0,1,1, 1, 0,8'h5A,1, 1,8'h02,0, 4'd1,4'd0});
    vecs.push_back('{8'h03,1,1,0,1,1, 1, 0,8'h5A,1, 1,8'h03,1, 4'd1,4'd1});
    vecs.push_back('{8'h11,1,0,0,0,1, 1, 1,8'h11,0, 0,8'h03,1, 4'd1,4'd1});
    vecs.push_back('{8'h12,1,1,1,0,1, 0, 1,8'h11,0, 0,8'h03,1, 4'd1,4'd1});
    vecs.push_back('{8'h12,1,1,1,0,1, 0, 1,8'h11,0, 0,8'h03,1, 4'd1,4'd1});
    vecs.push_back('{8'h12,1,1,1,1,1, 1, 1,8'h12,1, 0,8'h03,1, 4'd2,4'd1});
    vecs.push_back('{8'h00,0,0,0,1,1, 1, 0,8'h12,1, 0,8'h03,1, 4'd2,4'd1});
    vecs.push_back('{8'h21,1,1,1,1,0, 1, 0,8'h12,1, 1,8'h21,1, 4'd2,4'd2});
    vecs.push_back('{8'h31,1,0,0,1,0, 1, 1,8'h31,0, 1,8'h21,1, 4'd2,4'd2});
    vecs.push_back('{8'h32,1,0,1,1,0, 1, 1,8'h32,0, 1,8'h21,1, 4'd2,4'd2});
    vecs.push_back('{8'h33,1,1,1,1,0, 1, 1,8'h33,1, 1,8'h21,1, 4'd3,4'd2});
    vecs.push_back('{8'h00,0,0,1,0,0, 0, 1,8'h33,1, 1,8'h21,1, 4'd3,4'd2});
    vecs.push_back('{8'h41,1,1,1,0,1, 1, 1,8'h33,1, 1,8'h41,1, 4'd3,4'd3});
    vecs.push_back('{8'h42,1,1,0,1,0, 1, 1,8'h42,1, 1,8'h41,1, 4'd4,4'd3});
    vecs.push_back('{8'h00,0,0,0,1,1, 1, 0,8'h42,1, 0,8'h41,1, 4'd4,4'd3});

    // Reset values while RST is held
    #2 chk_all_zero("reset_init");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Directed table: single beat, packet lock, backpressure, independence
    foreach (vecs[i]) begin
      drive(vecs[i].d, vecs[i].v, vecs[i].l, vecs[i].s, vecs[i].ra, vecs[i].rb);
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_a", i), {bus.out_a_valid, bus.out_a, bus.out_a_last},
          {vecs[i].av, vecs[i].ad, vecs[i].al});
      chk($sformatf("vec%0d_b", i), {bus.out_b_valid, bus.out_b, bus.out_b_last},
          {vecs[i].bv, vecs[i].bd, vecs[i].bl});
      chk($sformatf("vec%0d_cnt", i), {bus.count_a, bus.count_b}, {vecs[i].ca, vecs[i].cb});
    end

    // Asynchronous reset with loaded registers and non-zero counters
    async_reset("reset_async");

    // Counter wrap: 16 back-to-back single-beat packets to A
    for (int i = 0; i < 16; i++) begin
      drive(8'(8'h60 + i), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk($sformatf("wrap%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("wrap%0d_a", i), {bus.out_a_valid, bus.out_a},
          {1'b1, 8'(8'h60 + i)});
      chk($sformatf("wrap%0d_count_a", i), 32'(bus.count_a), 32'((i + 1) % 16));
    end

    // Reset in the middle of a 4-beat packet to B
    async_reset("reset_pre_mid");
    drive(8'h51, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(8'h52, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("mid_beat2_b", {bus.out_b_valid, bus.out_b}, {1'b1, 8'h52});
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1 chk("mid_rst_b_valid", 32'(bus.out_b_valid), 32'd0);
    chk("mid_rst_count_b", 32'(bus.count_b), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(8'h61, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("mid_after_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    chk("mid_after_a", {bus.out_a_valid, bus.out_a, bus.out_a_last}, {1'b1, 8'h61, 1'b1});
    chk("mid_after_b_valid", 32'(bus.out_b_valid), 32'd0);
    chk("mid_after_cnt", {bus.count_a, bus.count_b}, {4'd1, 4'd0});

    // Randomized traffic against the queue model
    async_reset("reset_pre_rand");
    qa.delete();
    qb.delete();
    lock   = -1;
    mcnt_a = 0;
    mcnt_b = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int  tgt;
      logic exp_rdy;
      logic [8:0] beat;
      drive(8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            1'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6));
      @(negedge clk);

      // Outputs reflect the model's slots as of the last edge
      chk("rand_a_valid", 32'(bus.out_a_valid), 32'(qa.size() != 0));
      if (qa.size() != 0)
        chk("rand_a_beat", {bus.out_a_last, bus.out_a}, 32'(qa[0]));
      chk("rand_b_valid", 32'(bus.out_b_valid), 32'(qb.size() != 0));
      if (qb.size() != 0)
        chk("rand_b_beat", {bus.out_b_last, bus.out_b}, 32'(qb[0]));
      chk("rand_count_a", 32'(bus.count_a), 32'(mcnt_a % 16));
      chk("rand_count_b", 32'(bus.count_b), 32'(mcnt_b % 16));

      // A packet in flight keeps its channel; otherwise SEL picks it
      tgt     = (lock >= 0) ? lock : int'(bus.sel);
      exp_rdy = (tgt == 1) ? (qb.size() == 0 || bus.out_b_ready)
                           : (qa.size() == 0 || bus.out_a_ready);
      chk("rand_in_ready", 32'(bus.in_ready), 32'(exp_rdy));

      // Advance the model by one edge: consumers take, then producer pushes
      if (qa.size() != 0 && bus.out_a_ready) void'(qa.pop_front());
      if (qb.size() != 0 && bus.out_b_ready) void'(qb.pop_front());
      if (bus.in_valid && exp_rdy) begin
        beat = {bus.in_last, bus.in_data};
        if (tgt == 1) qb.push_back(beat);
        else          qa.push_back(beat);
        if (bus.in_last) begin
          if (tgt == 1) mcnt_b++;
          else          mcnt_a++;
          lock = -1;
        end else begin
          lock = tgt;
        end
      end
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
